// File: rtl/stage3_mem_wb_pkg.sv
// +-----------------------------------------------------------------------+
// | stage3_mem_wb_pkg : shared encodings and helpers for the MEM/WB stage  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package stage3_mem_wb_pkg;

  localparam int c_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  // x0 is hard-wired to zero, so a write to it is never enabled
  function automatic logic wb_enable(input logic regwrite, input logic [4:0] rd);
    return regwrite & (|rd);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wd_counter.sv
// +-----------------------------------------------------------------------+
// | mem_wd_counter : 8-bit saturating watchdog for outstanding dmem access|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module mem_wd_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [7:0] c_LIMIT = TIMEOUT[7:0];

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= 8'd0;
    end else if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_en && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = (r_count >= c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/stage3_mem_wb.sv
// +-----------------------------------------------------------------------+
// | stage3_mem_wb : MEM/WB stage, dmem ready handshake, WB register      |
// | Optional macro MEM_STAGE_STORE_FWD_EN adds a one-entry store buffer   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module stage3_mem_wb
  import stage3_mem_wb_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                NOS,
  input  logic                Ctl_MemRead_in,
  input  logic                Ctl_MemWrite_in,
  input  logic                Ctl_MemtoReg_in,
  input  logic                Ctl_RegWrite_in,
  input  logic [4:0]          Rd_in,
  input  logic [c_DATA_W-1:0] ALUresult_in,
  input  logic [c_DATA_W-1:0] MemWriteData_in,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [c_DATA_W-1:0] dmem_wdata,
  input  logic                dmem_ready,
  input  logic [c_DATA_W-1:0] dmem_rdata,
  output logic                stall,
  output logic                Ctl_RegWrite_out,
  output logic [4:0]          Rd_out,
  output logic [c_DATA_W-1:0] WriteData_out,
  output logic                mem_err
);

  state_t r_state;
  state_t w_state_nxt;

  logic                r_regwrite;
  logic [4:0]          r_rd;
  logic [c_DATA_W-1:0] r_wdata;

  logic                w_raw_mem;
  logic                w_mem_op;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_fwd_hit;
  logic [c_DATA_W-1:0] w_load_data;
  logic                w_req;
  logic                w_stall;
  logic                w_complete;
  logic                w_pass;
  logic                w_pass_we;
  logic                w_wd_clr;
  logic                w_wd_en;
  logic                w_wd_expired;

  assign w_raw_mem = Ctl_MemRead_in | Ctl_MemWrite_in;
  assign w_mem_op  = w_raw_mem & ~NOS & (r_state != ST_ERR);
  assign w_addr    = ALUresult_in[ADDR_W+1:2];
  // A killed or post-error memory op retires as a bubble
  assign w_pass_we = Ctl_RegWrite_in & ~NOS & ~(w_raw_mem & (r_state == ST_ERR));

`ifdef MEM_STAGE_STORE_FWD_EN
  logic                r_buf_valid;
  logic [ADDR_W-1:0]   r_buf_addr;
  logic [c_DATA_W-1:0] r_buf_data;

  assign w_fwd_hit   = r_buf_valid & Ctl_MemRead_in & ~Ctl_MemWrite_in & (r_buf_addr == w_addr);
  assign w_load_data = w_fwd_hit ? r_buf_data : dmem_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
    end else if (w_complete && Ctl_MemWrite_in) begin
      r_buf_valid <= 1'b1;
      r_buf_addr  <= w_addr;
      r_buf_data  <= MemWriteData_in;
    end
  end
`else
  assign w_fwd_hit   = 1'b0;
  assign w_load_data = dmem_rdata;
`endif

  mem_wd_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    w_complete  = 1'b0;
    w_pass      = 1'b0;
    w_wd_clr    = 1'b1;
    w_wd_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op) begin
          if (w_fwd_hit) begin
            w_complete = 1'b1;
          end else begin
            w_req = 1'b1;
            if (dmem_ready) begin
              w_complete = 1'b1;
            end else begin
              w_stall     = 1'b1;
              w_wd_clr    = 1'b0;
              w_wd_en     = 1'b1;
              w_state_nxt = ST_WAIT;
            end
          end
        end else begin
          w_pass = 1'b1;
        end
      end
      ST_WAIT: begin
        // NOS is ignored here: the access has already been issued
        w_req = 1'b1;
        if (dmem_ready) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_stall  = 1'b1;
          w_wd_clr = 1'b0;
          w_wd_en  = 1'b1;
          if (w_wd_expired) begin
            w_state_nxt = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        w_pass = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_regwrite <= 1'b0;
      r_rd       <= 5'd0;
      r_wdata    <= '0;
    end else if (w_complete) begin
      r_regwrite <= wb_enable(Ctl_RegWrite_in, Rd_in);
      r_rd       <= Rd_in;
      r_wdata    <= Ctl_MemtoReg_in ? w_load_data : ALUresult_in;
    end else if (w_pass) begin
      r_regwrite <= wb_enable(w_pass_we, Rd_in);
      r_rd       <= Rd_in;
      r_wdata    <= ALUresult_in;
    end else begin
      r_regwrite <= 1'b0;
    end
  end

  assign dmem_req         = w_req;
  assign dmem_we          = Ctl_MemWrite_in;
  assign dmem_addr        = w_addr;
  assign dmem_wdata       = MemWriteData_in;
  assign stall            = w_stall;
  assign Ctl_RegWrite_out = r_regwrite;
  assign Rd_out           = r_rd;
  assign WriteData_out    = r_wdata;
  assign mem_err          = (r_state == ST_ERR);

endmodule

`default_nettype wire
